// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV64I pipeline slice.
// Holds XLEN, the bubble encoding, the fetch FSM states and the IF/ID bundle.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, imem port and IF/ID outputs.
// The fetch stage takes the master view; its environment takes slave.
interface fetch_stage_if
    import riscv_pkg::*;
;

    logic            stall;
    logic            flush;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] Instr_Addr;
    logic [31:0]     Instruction;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic            halted;
    logic            fetch_fault;

    modport master (
        input  stall,
        input  flush,
        input  branch_taken,
        input  branch_target,
        input  Instruction,
        output Instr_Addr,
        output ifid_pc,
        output ifid_instr,
        output ifid_valid,
        output halted,
        output fetch_fault
    );

    modport slave (
        output stall,
        output flush,
        output branch_taken,
        output branch_target,
        output Instruction,
        input  Instr_Addr,
        input  ifid_pc,
        input  ifid_instr,
        input  ifid_valid,
        input  halted,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// A bubble keeps the previous pc so debug traces stay anchored.
module ifid_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output if_id_t          q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q.pc    <= '0;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (bubble) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q.pc    <= pc_in;
            q.instr <= instr_in;
            q.valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives imem and fills IF/ID; stops at end of program.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in a sticky FAULT state.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter logic [XLEN-1:0] IMEM_BYTES = 64'd40
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_inc;
    logic            fits_cur;
    logic            fits_tgt;
    logic            misaligned;
    logic            load;
    logic            bubble;
    if_id_t          ifid_q;

    assign pc_inc = pc + 64'd4;

    // 65-bit sums so a wrapped pc+4 can never look in range
    assign fits_cur = ({1'b0, pc} + 65'd4) <= {1'b0, IMEM_BYTES};
    assign fits_tgt = ({1'b0, bus.branch_target} + 65'd4)
                      <= {1'b0, IMEM_BYTES};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned      = |bus.branch_target[1:0];
    assign bus.fetch_fault = (state == FAULT);
`else
    assign misaligned      = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        bubble    = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.branch_taken) begin
                    bubble = 1'b1;
                    if (misaligned) begin
                        state_nxt = FAULT;
                    end else begin
                        pc_nxt = bus.branch_target;
                    end
                end else if (!fits_cur) begin
                    state_nxt = HALT;
                    bubble    = 1'b1;
                end else if (bus.stall) begin
                    bubble = bus.flush;
                end else if (bus.flush) begin
                    pc_nxt = pc_inc;
                    bubble = 1'b1;
                end else begin
                    pc_nxt = pc_inc;
                    load   = 1'b1;
                end
            end
            HALT: begin
                bubble = 1'b1;
                if (bus.branch_taken) begin
                    if (misaligned) begin
                        state_nxt = FAULT;
                    end else if (fits_tgt) begin
                        pc_nxt    = bus.branch_target;
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                bubble = 1'b1;
            end
        endcase
    end

    ifid_reg u_ifid (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .bubble   (bubble),
        .pc_in    (pc),
        .instr_in (bus.Instruction),
        .q        (ifid_q)
    );

    assign bus.Instr_Addr = pc;
    assign bus.ifid_pc    = ifid_q.pc;
    assign bus.ifid_instr = ifid_q.instr;
    assign bus.ifid_valid = ifid_q.valid;
    assign bus.halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed program walk, then random traffic.
// A rule-level model predicts each edge; a monitor compares after the edge.
module tb_fetch_stage;

    localparam logic [63:0] PROG_BYTES = 64'd40;
    localparam logic [31:0] NOP        = 32'h0000_0013;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ifid_pc;
        logic [31:0] ifid_instr;
        logic        ifid_valid;
        logic        halted;
        logic        fault;
    } exp_t;

    logic clk;
    logic reset;
    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC   (64'h0),
        .IMEM_BYTES (PROG_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [64];
    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        if (a > 64'd60) return 32'hBAD0_0BAD;
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    assign bus.Instruction = imem_word(bus.Instr_Addr);

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic        m_ifvalid;
    int          m_mode;   // 0 running, 1 halted, 2 faulted

    task automatic model_bubble();
        m_ifinstr = NOP;
        m_ifvalid = 1'b0;
    endtask

    task automatic step(input bit rst, input bit st, input bit fl,
                        input bit bt, input logic [63:0] tgt);
        exp_t e;
        bit   bad_align;
        @(negedge clk);
        reset             = rst;
        bus.stall         = st;
        bus.flush         = fl;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bad_align = ALIGN_EN && (tgt % 4 != 0);
        if (rst) begin
            m_pc = 0; m_mode = 0;
            m_ifpc = 0; m_ifinstr = NOP; m_ifvalid = 0;
        end else if (m_mode == 2) begin
            model_bubble();
        end else if (m_mode == 1) begin
            model_bubble();
            if (bt && bad_align) m_mode = 2;
            else if (bt && tgt <= PROG_BYTES - 4) begin
                m_pc = tgt; m_mode = 0;
            end
        end else if (bt) begin
            model_bubble();
            if (bad_align) m_mode = 2;
            else m_pc = tgt;
        end else if (m_pc > PROG_BYTES - 4) begin
            model_bubble();
            m_mode = 1;
        end else if (st) begin
            if (fl) model_bubble();
        end else if (fl) begin
            model_bubble();
            m_pc = m_pc + 4;
        end else begin
            m_ifpc = m_pc; m_ifinstr = imem_word(m_pc); m_ifvalid = 1;
            m_pc = m_pc + 4;
        end
        e.pc = m_pc;
        e.ifid_pc = m_ifpc;
        e.ifid_instr = m_ifinstr;
        e.ifid_valid = m_ifvalid;
        e.halted = (m_mode == 1);
        e.fault = (m_mode == 2);
        exp_q.push_back(e);
    endtask

    function automatic void chk(input string name,
                                input logic [63:0] got,
                                input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, got, want);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("Instr_Addr", bus.Instr_Addr, e.pc);
                chk("ifid_pc", bus.ifid_pc, e.ifid_pc);
                chk("ifid_instr", 64'(bus.ifid_instr), 64'(e.ifid_instr));
                chk("ifid_valid", 64'(bus.ifid_valid), 64'(e.ifid_valid));
                chk("halted", 64'(bus.halted), 64'(e.halted));
                chk("fetch_fault", 64'(bus.fetch_fault), 64'(e.fault));
            end
        end
    end

    initial begin
        logic [31:0] prog [16];
        logic [63:0] tgt;
        prog[0] = 32'h00e68633; prog[1] = 32'h40e68633;
        prog[2] = 32'h00371613; prog[3] = 32'h00a00093;
        prog[4] = 32'h00208113; prog[5] = 32'h00d03023;
        prog[6] = 32'h00f78463; prog[7] = 32'hfff10113;
        prog[8] = 32'h00f6c463; prog[9] = 32'h00000073;
        for (int i = 10; i < 16; i++) prog[i] = 32'hA5A5_0000 + 32'(i);
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 4; b++) mem[4*i+b] = prog[i][8*b +: 8];
        end

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 64'd32);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'd24);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'd34);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: tgt = 64'(4 * $urandom_range(0, 11));
                1: tgt = 64'($urandom_range(0, 47));
                2: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                default: tgt = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 tgt);
        end
        step(0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
